led_string_seq: RTL and testbench

Parametrised LED-string frame sequencer that holds a pixel frame buffer of NUM_LEDS entries and streams it through the existing per-pixel LED serializer (start frame, one LED frame per pixel, end frame) using the busy/start handshake. It adds a host write port, commit/done signalling, per-frame global brightness and selectable pixel order. Optional ping-pong buffering lets the host fill one frame while the other is sent. It sits between the pattern generator and the LED serializer.

---
 rtl/led_string_seq_if.sv | 14 +
 rtl/led_string_seq.sv | 133 +++++++++++++
 tb/tb_led_string_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_string_seq_if.sv
// led_string_seq_if: sequencer-to-serializer link (pixel frame fields plus start/busy handshake)
// Ports (modports): master drives led_type/colours/led_bright/led_start and samples led_busy;
//   slave is the serializer side.
interface led_string_seq_if #(parameter int COLOR_W = 8);
  logic [1:0] led_type;
  logic [COLOR_W-1:0] led_blue;
  logic [COLOR_W-1:0] led_green;
  logic [COLOR_W-1:0] led_red;
  logic [4:0] led_bright;
  logic led_start;
  logic led_busy;
  modport master (output led_type, led_blue, led_green, led_red, led_bright, led_start, input led_busy);
  modport slave (input led_type, led_blue, led_green, led_red, led_bright, led_start, output led_busy);
endinterface

// File: rtl/led_string_seq.sv
// led_string_seq: pixel frame buffer streamed to an LED serializer as START, one LED frame per pixel, END
// Ports: clk, rst_n (asynchronous active-low); host write port wr_en/wr_addr/wr_data/wr_ready;
//   commit with bright/reverse requests a frame; frame_busy/frame_done report progress;
//   led (led_string_seq_if.master) carries pixel fields and the led_start/led_busy handshake.
// Define LED_SEQ_DOUBLE_BUF_EN for two ping-pong banks with a one-deep pending commit.
module led_string_seq #(
  parameter int NUM_LEDS = 30,
  parameter int ADDR_W = 8,
  parameter int COLOR_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  output logic wr_ready,
  input  logic commit,
  input  logic [4:0] bright,
  input  logic reverse,
  output logic frame_busy,
  output logic frame_done,
  led_string_seq_if.master led
);
  typedef enum logic [2:0] {IDLE, WAIT_FREE, LOAD, REQ, ACK, NEXT, DONE} state_t;
  typedef enum logic [1:0] {PH_START = 2'd0, PH_PIXEL = 2'd1, PH_END = 2'd2} phase_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);
  state_t state, state_n;
  phase_t phase;
  logic [ADDR_W-1:0] idx;
  logic rev;
  logic [3*COLOR_W-1:0] rd_q;
  logic wr_ok, start, fin, again, new_rev;
  logic [4:0] new_bright;
  assign start = (state == IDLE) && commit;
  assign fin = (state == DONE) && !led.led_busy;
`ifdef LED_SEQ_DOUBLE_BUF_EN
  localparam int MW = ADDR_W + 1;
  logic front, pending, pend_rev;
  logic [4:0] pend_bright;
  logic [MW-1:0] wa, ra;
  assign wa = {~front, wr_addr};
  assign ra = {front, idx};
  assign wr_ready = 1'b1;
  // a commit arriving in the final DONE cycle is taken directly as the next frame
  assign again = fin && (pending || commit);
  assign new_rev = commit ? reverse : pend_rev;
  assign new_bright = commit ? bright : pend_bright;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      front <= 1'b0;
      pending <= 1'b0;
      pend_rev <= 1'b0;
      pend_bright <= '0;
    end else begin
      if (start || again) front <= ~front;
      if (again) pending <= 1'b0;
      else if (commit && state != IDLE) begin
        pending <= 1'b1;
        pend_rev <= reverse;
        pend_bright <= bright;
      end
    end
`else
  localparam int MW = ADDR_W;
  logic [MW-1:0] wa, ra;
  assign wa = wr_addr;
  assign ra = idx;
  assign wr_ready = ~frame_busy;
  assign again = 1'b0;
  assign new_rev = reverse;
  assign new_bright = bright;
`endif
  logic [3*COLOR_W-1:0] mem [2**MW];
  assign wr_ok = wr_en && wr_ready && ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_LEDS));
  // read every cycle; the address is stable in WAIT_FREE so LOAD sees the right pixel
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wa] <= wr_data;
    rd_q <= mem[ra];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = commit ? WAIT_FREE : IDLE;
      WAIT_FREE: state_n = led.led_busy ? WAIT_FREE : LOAD;
      LOAD:      state_n = REQ;
      REQ:       state_n = ACK;
      ACK:       state_n = led.led_busy ? NEXT : ACK;
      NEXT:      state_n = (phase == PH_END) ? DONE : WAIT_FREE;
      DONE:      state_n = led.led_busy ? DONE : (again ? WAIT_FREE : IDLE);
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= PH_START;
      idx <= '0;
      rev <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      led.led_start <= 1'b0;
      led.led_type <= '0;
      led.led_red <= '0;
      led.led_green <= '0;
      led.led_blue <= '0;
      led.led_bright <= '0;
    end else begin
      frame_busy <= state_n != IDLE;
      frame_done <= fin;
      led.led_start <= (state_n == REQ) || (state_n == ACK);
      if (start || again) begin
        phase <= PH_START;
        rev <= new_rev;
        led.led_bright <= new_bright;
      end
      if (state == LOAD) begin
        led.led_type <= phase;
        if (phase == PH_PIXEL) {led.led_red, led.led_green, led.led_blue} <= rd_q;
      end
      if (state == NEXT) begin
        if (phase == PH_START) begin
          phase <= PH_PIXEL;
          idx <= rev ? LAST : {ADDR_W{1'b0}};
        end else if (phase == PH_PIXEL) begin
          // end of string found by compare so idx never leaves 0..NUM_LEDS-1
          if (idx == (rev ? {ADDR_W{1'b0}} : LAST)) phase <= PH_END;
          else idx <= rev ? idx - ADDR_W'(1) : idx + ADDR_W'(1);
        end
      end
    end
endmodule

// File: tb/tb_led_string_seq.sv
// tb_led_string_seq: randomized scoreboard bench for led_string_seq with a busy-stretching serializer model
module tb_led_string_seq;
  localparam int N = 4;
  localparam int AW = 8;
  localparam int CW = 8;
`ifdef LED_SEQ_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic commit = 1'b0;
  logic reverse = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3*CW-1:0] wr_data = '0;
  logic [4:0] bright = '0;
  logic wr_ready, frame_busy, frame_done;
  led_string_seq_if #(.COLOR_W(CW)) led ();
  led_string_seq #(.NUM_LEDS(N), .ADDR_W(AW), .COLOR_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .commit(commit), .bright(bright), .reverse(reverse),
    .frame_busy(frame_busy), .frame_done(frame_done), .led(led)
  );
  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] t; logic [23:0] rgb; logic [4:0] br;} item_t;
  item_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int cap_cnt = 0;
  int busy_len = 3;
  int busy_cnt = 0;
  int hold_cnt = 0;
  int gap_until = 0;
  bit inflight = 1'b0;
  bit watch_gap = 1'b0;
  bit gap_seen = 1'b0;
  logic [23:0] buf_m [N];
  logic [23:0] front_m [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // serializer model plus scoreboard: every accepted led_start pops one expected item
  initial begin
    item_t e;
    led.led_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        done_cnt++;
`ifndef LED_SEQ_DOUBLE_BUF_EN
        check("busy_at_done", frame_busy, 0);
`endif
      end
`ifdef LED_SEQ_DOUBLE_BUF_EN
      if (watch_gap && done_cnt < gap_until && !frame_busy) gap_seen = 1'b1;
`endif
      if (rst_n && led.led_start && !led.led_busy) begin
        cap_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_frame: got type %0d with nothing expected", led.led_type);
        end else begin
          e = exp_q.pop_front();
          check("frame_item", {1'b0, led.led_type,
                (e.t == 2'd1) ? {led.led_red, led.led_green, led.led_blue} : e.rgb, led.led_bright}, {1'b0, e});
        end
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) busy_cnt--;
      if (hold_cnt > 0) hold_cnt--;
      led.led_busy = (busy_cnt > 0) || (hold_cnt > 0);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
    @(negedge clk);
    check("wr_ready", wr_ready, DBL ? 1'b1 : !inflight);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (int'(a) < N && (DBL || !inflight)) buf_m[a] = d;
  endtask

  task automatic fill(input logic [23:0] base, input logic [23:0] step);
    for (int i = 0; i < N; i++) wr(AW'(i), base + step * 24'(i));
  endtask

  // a frame is START, the pixels in the chosen order, END, all with the latched brightness
  task automatic do_commit(input logic [4:0] b, input logic r);
    logic [23:0] tmp [N];
    @(negedge clk);
    commit = 1'b1;
    bright = b;
    reverse = r;
    @(posedge clk);
    #1 commit = 1'b0;
    if (!inflight || DBL) begin
      tmp = front_m;
      front_m = buf_m;
      if (DBL) buf_m = tmp;
      exp_q.push_back({2'd0, 24'h0, b});
      for (int i = 0; i < N; i++) exp_q.push_back({2'd1, front_m[r ? N - 1 - i : i], b});
      exp_q.push_back({2'd2, 24'h0, b});
      exp_done++;
      inflight = 1'b1;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < exp_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_cnt, exp_done);
    inflight = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_caps(input int target);
    int n = 0;
    while (cap_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("cap_reached", cap_cnt >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int base;
    repeat (3) @(negedge clk);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_led_start", led.led_start, 0);
    check("rst_led_type", led.led_type, 0);
    check("rst_colours", {led.led_red, led.led_green, led.led_blue}, 0);
    check("rst_led_bright", led.led_bright, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // basic frame plus commit-to-start latency
    for (int i = 0; i < N; i++) wr(AW'(i), 24'h112233);
    do_commit(5'd31, 1'b0);
    check("busy_n1", frame_busy, 1);
    check("start_n1", led.led_start, 0);
    @(posedge clk);
    #1 check("start_n2", led.led_start, 0);
    @(posedge clk);
    #1 check("start_n3", led.led_start, 1);
    wait_done();
    // pixel order
    fill(24'h0, 24'h1);
    do_commit(5'd5, 1'b1);
    wait_done();
    fill(24'h0, 24'h1);
    do_commit(5'd7, 1'b0);
    wait_done();
    // out-of-range writes leave the buffer untouched
    fill(24'h0F0F00, 24'h010101);
    wr(AW'(N), 24'hFFFFFF);
    wr(8'hFF, 24'hFFFFFF);
    do_commit(5'd9, 1'b0);
    wait_done();
    // mid-frame rewrite and commit
    fill(24'h5A5A5A, 24'h0);
    do_commit(5'd10, 1'b0);
    base = cap_cnt;
    wait_caps(base + 2);
    gap_seen = 1'b0;
    for (int i = 0; i < N; i++) wr(AW'(i), 24'hAAAAAA);
    do_commit(5'd12, 1'b1);
    gap_until = exp_done;
    watch_gap = 1'b1;
    wait_done();
    watch_gap = 1'b0;
`ifdef LED_SEQ_DOUBLE_BUF_EN
    check("no_idle_gap", gap_seen, 0);
`endif
    repeat (40) @(negedge clk);
    check("done_after_midframe", done_cnt, exp_done);
    // serializer busy long before the frame
    fill(24'h102030, 24'h000001);
    @(negedge clk);
    hold_cnt = 50;
    do_commit(5'd20, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (led.led_start) seen = 1'b1;
    end
    check("start_held", seen, 0);
    wait_done();
    // randomized frames
    repeat (6) begin
      busy_len = $urandom_range(2, 5);
      for (int i = 0; i < N; i++) wr(AW'(i), 24'($urandom));
      repeat (2) wr(AW'($urandom_range(0, 7)), 24'($urandom));
      do_commit(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      wait_done();
    end
    // reset during the third LED frame
    busy_len = 3;
    fill(24'h334455, 24'h010000);
    do_commit(5'd17, 1'b0);
    base = cap_cnt;
    wait_caps(base + 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_start", led.led_start, 0);
    check("rst_mid_busy", frame_busy, 0);
    exp_q.delete();
    exp_done--;
    inflight = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_cnt, exp_done);
    fill(24'h778899, 24'h000101);
    do_commit(5'd3, 1'b1);
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
